// File: rtl/shift_pkg.sv
// Shared types for the shift/rotate pipeline: operation encoding and the
// per-stage record (sized for the widest supported N; stages use the low bits).
package shift_pkg;

  localparam int MAX_N  = 64;
  localparam int MAX_SW = 6;

  typedef enum logic [1:0] {
    ROTR = 2'b00,
    ROTL = 2'b01,
    SHR  = 2'b10,
    SHL  = 2'b11
  } op_e;

  typedef struct packed {
    logic              valid;
    op_e               op;
    logic [MAX_SW-1:0] amt;
    logic [MAX_N-1:0]  data;
  } stage_rec_t;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: conditionally shifts/rotates by 2^K and registers the
// result together with op and amount, with a valid/advance handshake.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [1:0]           op_i,
  input  logic [$clog2(N)-1:0] amt_i,
  input  logic [N-1:0]         data_i,
  input  logic                 adv_next_i,
  output logic                 adv_o,
  output logic                 valid_o,
  output logic [1:0]           op_o,
  output logic [$clog2(N)-1:0] amt_o,
  output logic [N-1:0]         data_o
);

  localparam int SW = $clog2(N);
  localparam int SH = 1 << K;

  stage_rec_t   rec_d, rec_q;
  logic [N-1:0] moved;

  function automatic logic [N-1:0] move_by(input logic [N-1:0] x, input op_e op);
    logic [N-1:0] y;
    case (op)
      ROTR:    y = (x >> SH) | (x << (N - SH));
      ROTL:    y = (x << SH) | (x >> (N - SH));
      SHR:     y = x >> SH;
      default: y = x << SH;
    endcase
    return y;
  endfunction

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign adv_o = !rec_q.valid || adv_next_i;

  always_comb begin
    moved = amt_i[K] ? move_by(data_i, op_e'(op_i)) : data_i;
    rec_d = rec_q;
    if (adv_o) begin
      rec_d                 = '0;
      rec_d.valid           = valid_i;
      rec_d.op              = op_e'(op_i);
      rec_d.amt[SW-1:0]     = amt_i;
      rec_d.data[N-1:0]     = moved;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q.valid <= 1'b0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign valid_o = rec_q.valid;
  assign op_o    = rec_q.op;
  assign amt_o   = rec_q.amt[SW-1:0];
  assign data_o  = rec_q.data[N-1:0];

  logic unused_hi;
  assign unused_hi = ^{rec_q.data, rec_q.amt};

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shifter/rotator: SW log-shifter stages with per-stage
// valid/ready backpressure, one result per cycle at L = SW cycles latency.
module shift_rotate_pipe
  import shift_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] b,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  s
);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [SW:0]         vld_c;
  logic [SW:0]         adv_c;
  logic [SW:0][1:0]    op_c;
  logic [SW:0][SW-1:0] amt_c;
  logic [SW:0][N-1:0]  data_c;

  assign vld_c[0]  = in_valid;
  assign op_c[0]   = op;
  assign amt_c[0]  = b;
  assign data_c[0] = a;
  assign adv_c[SW] = !vld_c[SW] || out_ready;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (vld_c[k]),
      .op_i       (op_c[k]),
      .amt_i      (amt_c[k]),
      .data_i     (data_c[k]),
      .adv_next_i (adv_c[k+1]),
      .adv_o      (adv_c[k]),
      .valid_o    (vld_c[k+1]),
      .op_o       (op_c[k+1]),
      .amt_o      (amt_c[k+1]),
      .data_o     (data_c[k+1])
    );
  end

  assign in_ready  = !rst && adv_c[0];
  assign out_valid = !rst && vld_c[SW];
  assign s         = out_valid ? data_c[SW] : '0;

  logic unused_tail;
  assign unused_tail = ^{op_c[SW], amt_c[SW]};

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe at N=8: directed vectors, stall/reset scenarios
// and a randomized run against a queue-based reference model.
module tb_shift_rotate_pipe;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [SW-1:0] b;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  s;

  int tests = 0;
  int fails = 0;
  logic [7:0] expq[$];

  logic [7:0] ba[4];
  logic [2:0] bb[4];
  logic [1:0] bo[4];
  logic [7:0] be[4];

  always #5 clk = ~clk;

  shift_rotate_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Rotation as a window into the doubled word; shifts as plain integer shifts.
  function automatic logic [7:0] ref_model(input logic [7:0] x, input int amt, input logic [1:0] o);
    int w;
    w = int'(x);
    case (o)
      2'b00:   return 8'((w | (w << 8)) >> amt);
      2'b01:   return 8'((w << amt) | (w >> (8 - amt)));
      2'b10:   return 8'(w >> amt);
      default: return 8'(w << amt);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(output bit acc, output bit got, output bit rdy);
    logic [7:0] e;
    @(negedge clk);
    rdy = in_ready;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    if (got) begin
      if (expq.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
      else begin
        e = expq.pop_front();
        chk("scoreboard", 32'(s), 32'(e));
      end
    end
    if (acc) expq.push_back(ref_model(a, int'(b), op));
    cyc();
  endtask

  // Four back-to-back inputs; results expected on cycles 3..6 after the first.
  task automatic burst4(input string tag);
    for (int j = 0; j < 8; j++) begin
      if (j < 4) begin
        in_valid = 1'b1; a = ba[j]; b = bb[j]; op = bo[j];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 4) chk($sformatf("%s_in_ready%0d", tag, j), {31'b0, in_ready}, 32'd1);
      chk($sformatf("%s_out_valid%0d", tag, j), {31'b0, out_valid}, (j >= 3 && j <= 6) ? 32'd1 : 32'd0);
      if (j >= 3 && j <= 6) chk($sformatf("%s_s%0d", tag, j - 3), 32'(s), 32'(be[j-3]));
      cyc();
    end
  endtask

  initial begin
    bit acc, got, rdy;
    int idx, nout, nacc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    cyc();

    // Single ROTR: result exactly three cycles after the transfer
    a = 8'hA5; b = 3'd1; op = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("lat_out_valid_c%0d", i), {31'b0, out_valid}, (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) chk("lat_s", 32'(s), 32'hD2);
      cyc();
    end

    ba = '{8'hA5, 8'h96, 8'hF0, 8'h01};
    bb = '{3'd1, 3'd3, 3'd4, 3'd7};
    bo = '{2'b00, 2'b01, 2'b10, 2'b11};
    be = '{8'hD2, 8'hB4, 8'h0F, 8'h80};
    burst4("b2b");

    ba = '{8'h5C, 8'h5C, 8'h5C, 8'h5C};
    bb = '{3'd0, 3'd0, 3'd0, 3'd0};
    be = '{8'h5C, 8'h5C, 8'h5C, 8'h5C};
    burst4("zero_amt");

    // Backpressure: fill with out_ready low, then release
    out_ready = 1'b0; idx = 0;
    repeat (8) begin
      in_valid = (idx < 6);
      a = 8'(8'h31 + 8'h22 * idx); b = 3'(idx + 1); op = 2'(idx);
      step(acc, got, rdy);
      if (acc) idx++;
    end
    chk("stall_accepted", 32'(idx), 32'd3);
    @(negedge clk);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_s_hold", 32'(s), 32'(ref_model(8'h31, 1, 2'b00)));
    cyc();
    out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 6);
      a = 8'(8'h31 + 8'h22 * idx); b = 3'(idx + 1); op = 2'(idx);
      step(acc, got, rdy);
      if (c == 0) chk("stall_no_bubble", {31'b0, rdy}, 32'd1);
      if (acc) idx++;
      if (got) nout++;
    end
    chk("stall_all_in", 32'(idx), 32'd6);
    chk("stall_all_out", 32'(nout), 32'd6);
    chk("stall_q_empty", 32'(expq.size()), 32'd0);

    // Reset with three items in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 8'(8'h7E + k); b = 3'(k + 2); op = 2'(k);
      step(acc, got, rdy);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    cyc();
    out_ready = 1'b1; nout = 0;
    repeat (6) begin
      step(acc, got, rdy);
      if (got) nout++;
    end
    chk("mid_rst_no_stale", 32'(nout), 32'd0);

    // Randomized traffic with random backpressure
    nacc = 0;
    for (int c = 0; c < 6000 && nacc < 1000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = 8'($urandom);
      b         = 3'($urandom);
      op        = 2'($urandom);
      out_ready = ($urandom_range(2) != 0);
      step(acc, got, rdy);
      if (acc) nacc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step(acc, got, rdy);
    chk("rand_count", {31'b0, (nacc >= 1000)}, 32'd1);
    chk("rand_drain_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_rotate_pipe.md
SHIFT_ROTATE_PIPE -- requirements
Module: shift_rotate_pipe

Interface
REQ-001 Parameter N, default 32: data width; SHALL be a power of two, N >= 4.
REQ-002 Parameter SW, default $clog2(N): shift-amount width; SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 in_valid  input  1  a, b and op are valid this cycle.
REQ-006 in_ready  output  1  pipeline accepts the input this cycle.
REQ-007 a  input  N  operand.
REQ-008 b  input  SW  shift/rotate amount, range 0..N-1.
REQ-009 op  input  2  operation: 00 ROTR, 01 ROTL, 10 SHR (logical), 11 SHL.
REQ-010 out_valid  output  1  s holds a completed result.
REQ-011 out_ready  input  1  consumer accepts s this cycle.
REQ-012 s  output  N  result.

Function
REQ-013 The block SHALL be a log-shifter pipeline of L = SW stages; stage k SHALL shift or rotate by 2^k when bit k of the amount carried with the data is 1, and SHALL pass the data through unchanged otherwise.
REQ-014 ROTR/ROTL SHALL wrap bits end-around; SHR/SHL SHALL zero-fill the vacated positions.
REQ-015 Each stage register SHALL hold valid, data, op and amount; the amount and op SHALL travel with the data.
REQ-016 A transfer SHALL occur on a cycle when valid and ready are both 1 on the same side.
REQ-017 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage SHALL advance when out_valid=0 or out_ready=1.
REQ-018 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances); it SHALL be combinational and SHALL NOT depend on in_valid.
REQ-019 With out_ready held at 1, latency from input transfer to out_valid SHALL be exactly L cycles, and throughput SHALL be 1 result per cycle.
REQ-020 While out_valid=1 and out_ready=0, s SHALL remain stable and no in-flight item SHALL be lost or duplicated.
REQ-021 A full pipeline with out_ready=0 SHALL drive in_ready=0; stalled stages SHALL keep their contents.
REQ-022 An input accepted on the same cycle that the last stage drains SHALL be processed without a bubble.
REQ-023 b=0 SHALL give s=a for every op.
REQ-024 Results SHALL emerge in input order.

Reset
REQ-025 While rst=1, all stage valid bits SHALL clear on the next clock edge; out_valid SHALL be 0 and s SHALL be 0.
REQ-026 in_ready SHALL be 0 during any cycle with rst=1.
REQ-027 rst asserted mid-operation SHALL discard all in-flight items; no result SHALL appear after rst deasserts unless a new input is transferred.
REQ-028 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-029 The shared package shift_pkg SHALL hold the op_e enum (ROTR, ROTL, SHR, SHL) and the stage-record typedef (valid, data, op, amount).
REQ-030 The sub-module shift_stage SHALL implement one stage; it SHALL take parameters N and K (stage index) and SHALL contain the stage register and its handshake.
REQ-031 The top level SHALL instantiate SW copies of shift_stage in a generate loop.

Verification (N=8, L=3)
REQ-032 a=8'hA5, b=1, ROTR, out_ready=1 -> s=8'hD2 with out_valid exactly 3 cycles after the transfer.
REQ-033 a=8'h96, b=3, ROTL -> s=8'hB4; a=8'hF0, b=4, SHR -> s=8'h0F; a=8'h01, b=7, SHL -> s=8'h80; all four issued back-to-back -> four results on four consecutive cycles, in order.
REQ-034 b=0 with each op on a=8'h5C -> s=8'h5C.
REQ-035 Stream 6 inputs with out_ready=0 -> in_ready drops after 3 accepted; s holds the first result; raise out_ready -> all 6 results emerge in order, none lost.
REQ-036 rst pulsed with 3 items in flight -> out_valid=0 and s=0 the next cycle; no stale result after release.
REQ-037 A randomized run of at least 1000 ops with random out_ready SHALL match a reference model on every transfer.
